cluster_width_pipe: RTL and testbench

- Pipelined, parametrised successor to the single-channel combinational Cb-width unit in the skin-tone nonlinear colour transform.
- Computes the luma-dependent cluster width for either Cb or Cr, selected per sample, as fixed-point.
- Uses precomputed slope constants, so there is no divider.
- Sits between the YCbCr input stage and the chroma-normalisation datapath, with valid/ready flow control and a pass-through tag.

---
 rtl/cluster_width_pipe.sv | 183 ++++++++++++++++++
 tb/tb_cluster_width_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_width_pipe.sv
`default_nettype none
// ==========================================================================
// cluster_width_pipe: 3-stage luma-dependent Cb/Cr cluster width, fixed-point
// Revision: 1.0
// ==========================================================================
module cluster_width_pipe #(
  parameter int FRAC_BITS = 8,
  parameter int INT_BITS  = 8,
  parameter int TAG_W     = 16,
  parameter int ZERO_MID  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_y,
  input  logic                          in_chan,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] out_width,
  output logic [1:0]                    out_region,
  output logic                          out_sat,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int OUT_W  = INT_BITS + FRAC_BITS;
  localparam int PROD_W = 8 + FRAC_BITS;
  localparam int SUM_W  = ((OUT_W > PROD_W) ? OUT_W : PROD_W) + 1;

  localparam logic [1:0] c_reg_low  = 2'b00;
  localparam logic [1:0] c_reg_mid  = 2'b01;
  localparam logic [1:0] c_reg_high = 2'b10;

  localparam int c_y_min_i = 16;
  localparam int c_y_max_i = 235;
  localparam int c_k_l_i   = 125;
  localparam int c_k_h_i   = 188;

  localparam logic [7:0] c_y_min = 8'(c_y_min_i);
  localparam logic [7:0] c_y_max = 8'(c_y_max_i);
  localparam logic [7:0] c_k_l   = 8'(c_k_l_i);
  localparam logic [7:0] c_k_h   = 8'(c_k_h_i);

  localparam real c_cb_w_r  = 46.97;
  localparam real c_cb_wl_r = 23.0;
  localparam real c_cb_wh_r = 14.0;
  localparam real c_cr_w_r  = 38.76;
  localparam real c_cr_wl_r = 20.0;
  localparam real c_cr_wh_r = 10.0;

  function automatic real pow2(input int n);
    real s;
    s = 1.0;
    for (int i = 0; i < n; i++) s = s * 2.0;
    return s;
  endfunction

  // Round-to-nearest quantisation of a non-negative real to FRAC_BITS.
  function automatic int quant(input real v);
    return $rtoi(v * pow2(FRAC_BITS) + 0.5);
  endfunction

  localparam logic [OUT_W-1:0] c_cb_w  = OUT_W'(quant(c_cb_w_r));
  localparam logic [OUT_W-1:0] c_cb_wl = OUT_W'(quant(c_cb_wl_r));
  localparam logic [OUT_W-1:0] c_cb_wh = OUT_W'(quant(c_cb_wh_r));
  localparam logic [OUT_W-1:0] c_cr_w  = OUT_W'(quant(c_cr_w_r));
  localparam logic [OUT_W-1:0] c_cr_wl = OUT_W'(quant(c_cr_wl_r));
  localparam logic [OUT_W-1:0] c_cr_wh = OUT_W'(quant(c_cr_wh_r));

  // Slopes come from the exact widths, not the quantised ones.
  localparam logic [FRAC_BITS-1:0] c_cb_sl =
    FRAC_BITS'(quant((c_cb_w_r - c_cb_wl_r) / real'(c_k_l_i - c_y_min_i)));
  localparam logic [FRAC_BITS-1:0] c_cb_sh =
    FRAC_BITS'(quant((c_cb_w_r - c_cb_wh_r) / real'(c_y_max_i - c_k_h_i)));
  localparam logic [FRAC_BITS-1:0] c_cr_sl =
    FRAC_BITS'(quant((c_cr_w_r - c_cr_wl_r) / real'(c_k_l_i - c_y_min_i)));
  localparam logic [FRAC_BITS-1:0] c_cr_sh =
    FRAC_BITS'(quant((c_cr_w_r - c_cr_wh_r) / real'(c_y_max_i - c_k_h_i)));

  logic                 w_adv;
  logic [1:0]           w_region;
  logic [7:0]           w_dy;
  logic [OUT_W-1:0]     w_base;
  logic [OUT_W-1:0]     w_mid_w;
  logic [FRAC_BITS-1:0] w_slope;
  logic [PROD_W-1:0]    w_prod;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_sat;
  logic [OUT_W-1:0]     w_width;

  logic                 r1_valid;
  logic [1:0]           r1_region;
  logic [7:0]           r1_dy;
  logic [OUT_W-1:0]     r1_base;
  logic [FRAC_BITS-1:0] r1_slope;
  logic [TAG_W-1:0]     r1_tag;

  logic                 r2_valid;
  logic [1:0]           r2_region;
  logic [OUT_W-1:0]     r2_base;
  logic [PROD_W-1:0]    r2_prod;
  logic [TAG_W-1:0]     r2_tag;

  // One global enable: every stage moves together, so bubbles stay in place.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  generate
    if (ZERO_MID != 0) begin : g_zero_mid
      assign w_mid_w = '0;
    end else begin : g_nominal_mid
      assign w_mid_w = in_chan ? c_cr_w : c_cb_w;
    end
  endgenerate

  // Mid region rides through the same datapath with a zero slope.
  always_comb begin
    w_region = c_reg_mid;
    w_dy     = 8'd0;
    w_base   = w_mid_w;
    w_slope  = '0;
    if (in_y <= c_k_l) begin
      w_region = c_reg_low;
      w_dy     = (in_y > c_y_min) ? (in_y - c_y_min) : 8'd0;
      w_base   = in_chan ? c_cr_wl : c_cb_wl;
      w_slope  = in_chan ? c_cr_sl : c_cb_sl;
    end else if (in_y >= c_k_h) begin
      w_region = c_reg_high;
      w_dy     = (in_y < c_y_max) ? (c_y_max - in_y) : 8'd0;
      w_base   = in_chan ? c_cr_wh : c_cb_wh;
      w_slope  = in_chan ? c_cr_sh : c_cb_sh;
    end
  end

  assign w_prod  = PROD_W'(r1_dy) * PROD_W'(r1_slope);

  assign w_sum   = SUM_W'(r2_base) + SUM_W'(r2_prod);
  assign w_sat   = |w_sum[SUM_W-1:OUT_W];
  assign w_width = w_sat ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_region  <= '0;
      r1_dy      <= '0;
      r1_base    <= '0;
      r1_slope   <= '0;
      r1_tag     <= '0;
      r2_valid   <= 1'b0;
      r2_region  <= '0;
      r2_base    <= '0;
      r2_prod    <= '0;
      r2_tag     <= '0;
      out_valid  <= 1'b0;
      out_width  <= '0;
      out_region <= '0;
      out_sat    <= 1'b0;
      out_tag    <= '0;
    end else if (w_adv) begin
      r1_valid   <= in_valid;
      r1_region  <= w_region;
      r1_dy      <= w_dy;
      r1_base    <= w_base;
      r1_slope   <= w_slope;
      r1_tag     <= in_tag;

      r2_valid   <= r1_valid;
      r2_region  <= r1_region;
      r2_base    <= r1_base;
      r2_prod    <= w_prod;
      r2_tag     <= r1_tag;

      out_valid  <= r2_valid;
      out_width  <= w_width;
      out_region <= r2_region;
      out_sat    <= w_sat;
      out_tag    <= r2_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cluster_width_pipe.sv
`default_nettype none
// Bench for cluster_width_pipe: nominal and ZERO_MID instances share one stimulus stream.
module tb_cluster_width_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_y;
  logic        in_chan;
  logic [15:0] in_tag;
  logic        out_ready;

  logic        ir0, ov0, os0;
  logic [15:0] ow0, ot0;
  logic [1:0]  or0;
  logic        ir1, ov1, os1;
  logic [15:0] ow1, ot1;
  logic [1:0]  or1;

  cluster_width_pipe #(.FRAC_BITS(8), .INT_BITS(8), .TAG_W(16), .ZERO_MID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_y(in_y),
    .in_chan(in_chan), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
    .out_width(ow0), .out_region(or0), .out_sat(os0), .out_tag(ot0));

  cluster_width_pipe #(.FRAC_BITS(8), .INT_BITS(8), .TAG_W(16), .ZERO_MID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_y(in_y),
    .in_chan(in_chan), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
    .out_width(ow1), .out_region(or1), .out_sat(os1), .out_tag(ot1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    int ch;
    int tag;
    int acc;
  } ent_t;

  ent_t sb[$];
  int   rd[2];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   rand_ready = 1'b0;

  int log_w   [2][0:1023];
  int log_r   [2][0:1023];
  int log_s   [2][0:1023];
  int log_t   [2][0:1023];
  int log_lat [2][0:1023];
  int log_n   [2];

  bit hold[2];
  int pw[2], pr[2], ps[2], pt[2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Unsaturated result straight from the published constants at FRAC_BITS=8.
  function automatic int model_sum(input int y, input int ch, input bit zmid);
    int w, wl, wh, sl, sh, dy;
    if (ch == 0) begin w = 12024; wl = 5888; wh = 3584; sl = 56; sh = 180; end
    else         begin w = 9923;  wl = 5120; wh = 2560; sl = 44; sh = 157; end
    if (y <= 125) begin
      dy = (y > 16) ? y - 16 : 0;
      return wl + dy * sl;
    end
    if (y >= 188) begin
      dy = (y < 235) ? 235 - y : 0;
      return wh + dy * sh;
    end
    return zmid ? 0 : w;
  endfunction

  function automatic int model_region(input int y);
    if (y <= 125) return 0;
    if (y >= 188) return 2;
    return 1;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        rd[0] = 0; rd[1] = 0;
        hold[0] = 1'b0; hold[1] = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          logic v, rdy;
          int w, r, s, t, es, ew;
          ent_t e;
          v   = (k == 0) ? ov0 : ov1;
          rdy = (k == 0) ? ir0 : ir1;
          w   = (k == 0) ? int'(ow0) : int'(ow1);
          r   = (k == 0) ? int'(or0) : int'(or1);
          s   = (k == 0) ? int'(os0) : int'(os1);
          t   = (k == 0) ? int'(ot0) : int'(ot1);
          if (hold[k]) begin
            chk($sformatf("inst%0d_hold_valid", k), v, 1);
            chk($sformatf("inst%0d_hold_width", k), w, pw[k]);
            chk($sformatf("inst%0d_hold_region", k), r, pr[k]);
            chk($sformatf("inst%0d_hold_sat", k), s, ps[k]);
            chk($sformatf("inst%0d_hold_tag", k), t, pt[k]);
          end
          if (v && !out_ready) chk($sformatf("inst%0d_stall_in_ready", k), rdy, 0);
          if (v && out_ready) begin
            chk($sformatf("inst%0d_output_expected", k), sb.size() > rd[k], 1);
            if (rd[k] < sb.size()) begin
              e  = sb[rd[k]];
              es = model_sum(e.y, e.ch, k == 1);
              ew = (es > 65535) ? 65535 : es;
              chk($sformatf("inst%0d_width y=%0d ch=%0d", k, e.y, e.ch), w, ew);
              chk($sformatf("inst%0d_region y=%0d", k, e.y), r, model_region(e.y));
              chk($sformatf("inst%0d_sat y=%0d", k, e.y), s, (es > 65535) ? 1 : 0);
              chk($sformatf("inst%0d_tag", k), t, e.tag);
              if (log_n[k] < 1024) begin
                log_w[k][log_n[k]]   = w;
                log_r[k][log_n[k]]   = r;
                log_s[k][log_n[k]]   = s;
                log_t[k][log_n[k]]   = t;
                log_lat[k][log_n[k]] = cyc - e.acc;
                log_n[k]++;
              end
              rd[k]++;
            end
          end
          hold[k] = v && !out_ready;
          pw[k] = w; pr[k] = r; ps[k] = s; pt[k] = t;
        end
        if (in_valid && ir0) begin
          chk("in_ready_match", ir1, ir0);
          sb.push_back('{y: int'(in_y), ch: int'(in_chan), tag: int'(in_tag), acc: cyc});
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int y, input int ch, input int tag);
    int  n;
    bit  ok;
    n = 0; ok = 1'b0;
    in_valid = 1'b1; in_y = 8'(y); in_chan = ch[0]; in_tag = 16'(tag);
    while (!ok && n < 200) begin
      @(negedge clk);
      if (ir0) ok = 1'b1;
      n++;
    end
    chk("send_accepted", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rd[0] != sb.size() || rd[1] != sb.size()) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_inst0", rd[0], sb.size());
    chk("drain_inst1", rd[1], sb.size());
  endtask

  task automatic clear_log();
    log_n[0] = 0; log_n[1] = 0;
  endtask

  int y1[5]  = '{16, 125, 150, 188, 235};
  int ew1[5] = '{5888, 11992, 12024, 12044, 3584};
  int er1[5] = '{0, 0, 1, 2, 2};
  int y2[4]  = '{200, 16, 0, 255};
  int c2[4]  = '{1, 1, 0, 1};
  int ew2[4] = '{8055, 5120, 5888, 2560};
  int y3[6]  = '{20, 60, 140, 190, 230, 250};

  initial begin : main
    rst_n = 1'b0; in_valid = 1'b0; in_y = '0; in_chan = 1'b0; in_tag = '0;
    out_ready = 1'b1; log_n[0] = 0; log_n[1] = 0; rd[0] = 0; rd[1] = 0;

    chk("model_cb_y125", model_sum(125, 0, 0), 11992);
    chk("model_cr_y200", model_sum(200, 1, 0), 8055);
    chk("model_cb_y0", model_sum(0, 0, 0), 5888);
    chk("model_cr_y255", model_sum(255, 1, 0), 2560);
    chk("model_zero_mid", model_sum(150, 0, 1), 0);

    cycles(3);
    rst_n = 1'b1;
    chk("reset_out_valid", ov0, 0);
    chk("reset_out_width", ow0, 0);
    chk("reset_out_region", or0, 0);
    chk("reset_out_sat", os0, 0);
    chk("reset_out_tag", ot0, 0);
    chk("reset_in_ready", ir0, 1);

    // Back-to-back Cb with out_ready high.
    clear_log();
    for (int i = 0; i < 5; i++) send(y1[i], 0, 16'h100 + i);
    drain();
    chk("t1_count", log_n[0], 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_width_%0d", i), log_w[0][i], ew1[i]);
      chk($sformatf("t1_region_%0d", i), log_r[0][i], er1[i]);
      chk($sformatf("t1_latency_%0d", i), log_lat[0][i], 3);
    end

    // Cr and clamped extremes.
    clear_log();
    for (int i = 0; i < 4; i++) send(y2[i], c2[i], 16'h200 + i);
    drain();
    chk("t2_count", log_n[0], 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_width_%0d", i), log_w[0][i], ew2[i]);
      chk($sformatf("t2_sat_%0d", i), log_s[0][i], 0);
    end

    // Backpressure in the middle of a 6-sample stream.
    clear_log();
    fork
      begin
        for (int i = 0; i < 6; i++) send(y3[i], i % 2, 16'hA0 + i);
      end
      begin
        cycles(3);
        out_ready = 1'b0;
        cycles(4);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_count", log_n[0], 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_tag_%0d", i), log_t[0][i], 16'hA0 + i);

    // Diagnostic zero-mid instance.
    clear_log();
    send(150, 0, 16'h300);
    send(125, 0, 16'h301);
    drain();
    chk("t4_zm_width_mid", log_w[1][0], 0);
    chk("t4_zm_region_mid", log_r[1][0], 1);
    chk("t4_zm_width_low", log_w[1][1], 11992);
    chk("t4_nominal_width_mid", log_w[0][0], 12024);

    // Reset while three samples are stalled in flight.
    clear_log();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(40 + i, 0, 16'h400 + i);
    cycles(2);
    chk("t5_stalled_valid", ov0, 1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    chk("t5_inst0_valid_after_reset", ov0, 0);
    chk("t5_inst1_valid_after_reset", ov1, 0);
    out_ready = 1'b1;
    cycles(6);
    chk("t5_no_stale_output", log_n[0], 0);
    send(100, 1, 16'h4FF);
    drain();
    chk("t5_count", log_n[0], 1);
    chk("t5_latency", log_lat[0][0], 3);
    chk("t5_width", log_w[0][0], 5120 + 84 * 44);
    chk("t5_tag", log_t[0][0], 16'h4FF);

    // Full sweep on both channels with random gaps and random out_ready.
    clear_log();
    rand_ready = 1'b1;
    for (int y = 0; y < 256; y++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 3) == 0) cycles(1);
        send(y, ch, y * 2 + ch);
      end
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    chk("t6_count_inst0", log_n[0], 512);
    chk("t6_count_inst1", log_n[1], 512);

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
